// File: rtl/sync_fifo_pkg.sv
// Sizing helpers and configuration checks shared by the synchronous FIFO family.
// All helpers are constant functions so they can size ports and parameters.
package sync_fifo_pkg;

    function automatic int unsigned min_width(int unsigned w, int unsigned r);
        return (w < r) ? w : r;
    endfunction

    function automatic int unsigned max_width(int unsigned w, int unsigned r);
        return (w > r) ? w : r;
    endfunction

    function automatic int unsigned ratio(int unsigned w, int unsigned r);
        return max_width(w, r) / min_width(w, r);
    endfunction

    // Narrow units moved by one access on a port of width `side`.
    function automatic int unsigned units(int unsigned side, int unsigned w, int unsigned r);
        return side / min_width(w, r);
    endfunction

    function automatic bit is_pow2(int unsigned x);
        return (x != 0) && ((x & (x - 1)) == 0);
    endfunction

    function automatic bit cfg_ok(int unsigned w, int unsigned r, int unsigned depth,
                                  int unsigned af, int unsigned ae);
        return (min_width(w, r) != 0) && (max_width(w, r) % min_width(w, r) == 0) &&
               is_pow2(depth) && (depth >= 2) && (depth % ratio(w, r) == 0) &&
               (af <= depth) && (ae <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_wconv_ram.sv
// Unit-granular register array: WU-unit write port, RU-unit combinational read port.
// Addresses wrap modulo DEPTH_U; contents are deliberately not reset.
module sync_fifo_wconv_ram #(
    parameter int unsigned U       = 16,
    parameter int unsigned DEPTH_U = 16,
    parameter int unsigned WU      = 1,
    parameter int unsigned RU      = 2
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH_U)-1:0]   wr_addr,
    input  logic [WU*U-1:0]              wr_units,
    input  logic [$clog2(DEPTH_U)-1:0]   rd_addr,
    output logic [RU*U-1:0]              rd_units
);

    localparam int unsigned AW = $clog2(DEPTH_U);

    logic [U-1:0] mem_q [DEPTH_U];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WU; i++) begin
                mem_q[wr_addr + AW'(i)] <= wr_units[i*U +: U];
            end
        end
    end

    always_comb begin
        rd_units = '0;
        for (int i = 0; i < RU; i++) begin
            rd_units[i*U +: U] = mem_q[rd_addr + AW'(i)];
        end
    end

endmodule

// File: rtl/sync_fifo_wconv.sv
// Single-clock FIFO with integer-ratio write/read widths (pack or unpack).
// Holds unit pointers, flags and the wide-word unit ordering; storage is in the RAM sub-module.
module sync_fifo_wconv
    import sync_fifo_pkg::*;
#(
    parameter int unsigned W_WIDTH   = 16,
    parameter int unsigned R_WIDTH   = 32,
    parameter int unsigned DEPTH_U   = 16,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned AF_THRESH = DEPTH_U - ratio(W_WIDTH, R_WIDTH),
    parameter int unsigned AE_THRESH = ratio(W_WIDTH, R_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_valid,
    input  logic [W_WIDTH-1:0]         wr_data,
    output logic                       wr_ready,
    output logic                       rd_valid,
    output logic [R_WIDTH-1:0]         rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH_U):0]   level,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned U  = min_width(W_WIDTH, R_WIDTH);
    localparam int unsigned WU = units(W_WIDTH, W_WIDTH, R_WIDTH);
    localparam int unsigned RU = units(R_WIDTH, W_WIDTH, R_WIDTH);
    localparam int unsigned LW = $clog2(DEPTH_U) + 1;
    localparam int unsigned AW = LW - 1;

    if (!cfg_ok(W_WIDTH, R_WIDTH, DEPTH_U, AF_THRESH, AE_THRESH)) begin : g_cfg_err
        $error("sync_fifo_wconv: illegal width/depth/threshold configuration");
    end

    logic [LW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d, underflow_q, underflow_d;
    logic            wr_fire, rd_fire;
    logic [WU*U-1:0] wr_units;
    logic [RU*U-1:0] rd_units;

    // Flags come straight from registered pointers, so a same-cycle read never frees a write.
    always_comb begin
        level        = wr_ptr_q - rd_ptr_q;
        wr_ready     = level <= LW'(DEPTH_U - WU);
        rd_valid     = level >= LW'(RU);
        almost_full  = level >= LW'(AF_THRESH);
        almost_empty = level <= LW'(AE_THRESH);
        overflow     = overflow_q;
        underflow    = underflow_q;
        wr_fire      = wr_valid & wr_ready & ~flush;
        rd_fire      = rd_valid & rd_ready & ~flush;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q | (wr_valid & ~wr_ready);
        underflow_d = underflow_q | (rd_ready & ~rd_valid);
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + LW'(WU);
            if (rd_fire) rd_ptr_d = rd_ptr_q + LW'(RU);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Unit i of the RAM ports is the i-th unit in time; map it to its slice of the wide word.
    always_comb begin
        wr_units = '0;
        rd_data  = '0;
        for (int i = 0; i < WU; i++) begin
            wr_units[i*U +: U] = LSB_FIRST ? wr_data[i*U +: U] : wr_data[(WU-1-i)*U +: U];
        end
        for (int i = 0; i < RU; i++) begin
            if (LSB_FIRST) rd_data[i*U +: U] = rd_units[i*U +: U];
            else           rd_data[(RU-1-i)*U +: U] = rd_units[i*U +: U];
        end
    end

    sync_fifo_wconv_ram #(
        .U       (U),
        .DEPTH_U (DEPTH_U),
        .WU      (WU),
        .RU      (RU)
    ) u_ram (
        .clk      (clk),
        .wr_en    (wr_fire),
        .wr_addr  (wr_ptr_q[AW-1:0]),
        .wr_units (wr_units),
        .rd_addr  (rd_ptr_q[AW-1:0]),
        .rd_units (rd_units)
    );

endmodule

// File: tb/tb_sync_fifo_wconv.sv
// Bench for sync_fifo_wconv: an upsizing (16->32, LSB first) and a downsizing (32->16, MS first)
// instance, each compared every cycle against a queue-of-units model, plus literal directed checks.
module tb_sync_fifo_wconv;

    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        a_flush, a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready;
    logic        a_af, a_ae, a_ovf, a_udf;
    logic [15:0] a_wr_data;
    logic [31:0] a_rd_data;
    logic [4:0]  a_level;

    logic        b_flush, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready;
    logic        b_af, b_ae, b_ovf, b_udf;
    logic [31:0] b_wr_data;
    logic [15:0] b_rd_data;
    logic [4:0]  b_level;

    sync_fifo_wconv #(
        .W_WIDTH   (16),
        .R_WIDTH   (32),
        .DEPTH_U   (16),
        .LSB_FIRST (1'b1)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (a_flush),
        .wr_valid     (a_wr_valid),
        .wr_data      (a_wr_data),
        .wr_ready     (a_wr_ready),
        .rd_valid     (a_rd_valid),
        .rd_data      (a_rd_data),
        .rd_ready     (a_rd_ready),
        .level        (a_level),
        .almost_full  (a_af),
        .almost_empty (a_ae),
        .overflow     (a_ovf),
        .underflow    (a_udf)
    );

    sync_fifo_wconv #(
        .W_WIDTH   (32),
        .R_WIDTH   (16),
        .DEPTH_U   (16),
        .LSB_FIRST (1'b0)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (b_flush),
        .wr_valid     (b_wr_valid),
        .wr_data      (b_wr_data),
        .wr_ready     (b_wr_ready),
        .rd_valid     (b_rd_valid),
        .rd_data      (b_rd_data),
        .rd_ready     (b_rd_ready),
        .level        (b_level),
        .almost_full  (b_af),
        .almost_empty (b_ae),
        .overflow     (b_ovf),
        .underflow    (b_udf)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Model: each FIFO is a queue of 16-bit units in arrival order, plus sticky flags.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic        qa_ovf = 1'b0, qa_udf = 1'b0, qb_ovf = 1'b0, qb_udf = 1'b0;

    task automatic model_a();
        int sz;
        bit wf, rf;
        sz = qa.size();
        wf = a_wr_valid && (DEPTH - sz >= 1);
        rf = a_rd_ready && (sz >= 2);
        if (a_flush) begin
            qa.delete();
            qa_ovf <= 1'b0;
            qa_udf <= 1'b0;
        end else begin
            if (a_wr_valid && !wf) qa_ovf <= 1'b1;
            if (a_rd_ready && sz < 2) qa_udf <= 1'b1;
            if (rf) begin
                void'(qa.pop_front());
                void'(qa.pop_front());
            end
            if (wf) qa.push_back(a_wr_data);
        end
    endtask

    task automatic model_b();
        int sz;
        bit wf, rf;
        sz = qb.size();
        wf = b_wr_valid && (DEPTH - sz >= 2);
        rf = b_rd_ready && (sz >= 1);
        if (b_flush) begin
            qb.delete();
            qb_ovf <= 1'b0;
            qb_udf <= 1'b0;
        end else begin
            if (b_wr_valid && !wf) qb_ovf <= 1'b1;
            if (b_rd_ready && sz < 1) qb_udf <= 1'b1;
            if (rf) void'(qb.pop_front());
            if (wf) begin
                qb.push_back(b_wr_data[31:16]);
                qb.push_back(b_wr_data[15:0]);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            qa_ovf <= 1'b0;
            qa_udf <= 1'b0;
            qb_ovf <= 1'b0;
            qb_udf <= 1'b0;
        end else begin
            model_a();
            model_b();
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        int sa, sb;
        sa = qa.size();
        sb = qb.size();
        chk("a_level", 32'(a_level), 32'(sa));
        chk("a_wr_ready", 32'(a_wr_ready), 32'(DEPTH - sa >= 1));
        chk("a_rd_valid", 32'(a_rd_valid), 32'(sa >= 2));
        chk("a_almost_full", 32'(a_af), 32'(sa >= DEPTH - 2));
        chk("a_almost_empty", 32'(a_ae), 32'(sa <= 2));
        chk("a_overflow", 32'(a_ovf), 32'(qa_ovf));
        chk("a_underflow", 32'(a_udf), 32'(qa_udf));
        if (sa >= 2) chk("a_rd_data", a_rd_data, {qa[1], qa[0]});
        chk("b_level", 32'(b_level), 32'(sb));
        chk("b_wr_ready", 32'(b_wr_ready), 32'(DEPTH - sb >= 2));
        chk("b_rd_valid", 32'(b_rd_valid), 32'(sb >= 1));
        chk("b_almost_full", 32'(b_af), 32'(sb >= DEPTH - 2));
        chk("b_almost_empty", 32'(b_ae), 32'(sb <= 2));
        chk("b_overflow", 32'(b_ovf), 32'(qb_ovf));
        chk("b_underflow", 32'(b_udf), 32'(qb_udf));
        if (sb >= 1) chk("b_rd_data", 32'(b_rd_data), 32'(qb[0]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_a_level"}, 32'(a_level), 32'd0);
        chk({tag, "_a_wr_ready"}, 32'(a_wr_ready), 32'd1);
        chk({tag, "_a_rd_valid"}, 32'(a_rd_valid), 32'd0);
        chk({tag, "_a_ae"}, 32'(a_ae), 32'd1);
        chk({tag, "_a_af"}, 32'(a_af), 32'd0);
        chk({tag, "_a_ovf"}, 32'(a_ovf), 32'd0);
        chk({tag, "_a_udf"}, 32'(a_udf), 32'd0);
    endtask

    initial begin
        a_flush = 0; a_wr_valid = 0; a_wr_data = '0; a_rd_ready = 0;
        b_flush = 0; b_wr_valid = 0; b_wr_data = '0; b_rd_ready = 0;
        #1 rst_n = 1'b0;
        #1;
        chk_reset_a("rst");
        chk("rst_b_level", 32'(b_level), 32'd0);
        chk("rst_b_rd_valid", 32'(b_rd_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Upsize packing, LSB first.
        a_wr_valid = 1; a_wr_data = 16'h1111;
        step();
        chk("pack_lvl1", 32'(a_level), 32'd1);
        chk("pack_nvalid", 32'(a_rd_valid), 32'd0);
        a_wr_data = 16'h2222;
        step();
        chk("pack_lvl2", 32'(a_level), 32'd2);
        chk("pack_valid", 32'(a_rd_valid), 32'd1);
        chk("pack_data", a_rd_data, 32'h2222_1111);
        a_wr_valid = 0; a_rd_ready = 1;
        step();
        chk("pack_lvl0", 32'(a_level), 32'd0);
        a_rd_ready = 0;

        // Downsize unpacking, MS slice first.
        b_wr_valid = 1; b_wr_data = 32'hAAAA_BBBB;
        step();
        b_wr_valid = 0;
        chk("unpack_lvl2", 32'(b_level), 32'd2);
        chk("unpack_d0", 32'(b_rd_data), 32'h0000_AAAA);
        b_rd_ready = 1;
        step();
        chk("unpack_lvl1", 32'(b_level), 32'd1);
        chk("unpack_d1", 32'(b_rd_data), 32'h0000_BBBB);
        step();
        chk("unpack_lvl0", 32'(b_level), 32'd0);
        chk("unpack_empty", 32'(b_rd_valid), 32'd0);
        b_rd_ready = 0;

        // Fill to full, blocked write, flush (with a write pending) clears everything.
        a_wr_valid = 1;
        for (int i = 0; i < 16; i++) begin
            a_wr_data = 16'(i + 1);
            step();
        end
        chk("full_lvl", 32'(a_level), 32'd16);
        chk("full_wr_ready", 32'(a_wr_ready), 32'd0);
        chk("full_af", 32'(a_af), 32'd1);
        chk("full_no_ovf", 32'(a_ovf), 32'd0);
        step();
        chk("ovf_set", 32'(a_ovf), 32'd1);
        chk("ovf_lvl", 32'(a_level), 32'd16);
        a_flush = 1;
        step();
        a_flush = 0; a_wr_valid = 0;
        chk("flush_lvl", 32'(a_level), 32'd0);
        chk("flush_ovf", 32'(a_ovf), 32'd0);

        // Read on empty, then normal traffic.
        a_rd_ready = 1;
        step();
        chk("udf_set", 32'(a_udf), 32'd1);
        chk("udf_lvl", 32'(a_level), 32'd0);
        a_rd_ready = 0; a_wr_valid = 1; a_wr_data = 16'h1234;
        step();
        a_wr_data = 16'h5678;
        step();
        a_wr_valid = 0;
        chk("udf_after_data", a_rd_data, 32'h5678_1234);
        a_rd_ready = 1;
        step();
        a_rd_ready = 0;
        chk("udf_after_lvl", 32'(a_level), 32'd0);
        chk("udf_sticky", 32'(a_udf), 32'd1);
        a_flush = 1;
        step();
        a_flush = 0;
        chk("udf_clr", 32'(a_udf), 32'd0);

        // Steady state at level 8: write every cycle, read every second cycle.
        a_wr_valid = 1;
        for (int i = 0; i < 8; i++) begin
            a_wr_data = 16'($urandom);
            step();
        end
        chk("steady_lvl_start", 32'(a_level), 32'd8);
        for (int i = 0; i < 128; i++) begin
            a_wr_data  = 16'($urandom);
            a_rd_ready = (i % 2 == 1);
            step();
            if (i % 2 == 1) chk("steady_lvl", 32'(a_level), 32'd8);
        end
        a_wr_valid = 0; a_rd_ready = 1;
        for (int i = 0; i < 4; i++) step();
        a_rd_ready = 0;
        chk("steady_drained", 32'(a_level), 32'd0);

        // Async reset at an odd unit count, with a sticky flag pending on B.
        a_wr_valid = 1;
        for (int i = 0; i < 5; i++) begin
            a_wr_data = 16'hC000 + 16'(i);
            step();
        end
        a_wr_valid = 0; b_rd_ready = 1;
        step();
        b_rd_ready = 0;
        chk("pre_rst_lvl", 32'(a_level), 32'd5);
        chk("pre_rst_b_udf", 32'(b_udf), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_a("midrst");
        chk("midrst_b_udf", 32'(b_udf), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_wr_valid = 1; a_wr_data = 16'hAAAA;
        step();
        a_wr_data = 16'hBBBB;
        step();
        a_wr_valid = 0;
        chk("post_rst_lvl", 32'(a_level), 32'd2);
        chk("post_rst_data", a_rd_data, 32'hBBBB_AAAA);
        a_rd_ready = 1;
        step();
        a_rd_ready = 0;
        chk("post_rst_empty", 32'(a_level), 32'd0);

        // Random traffic on both instances, occasional flush.
        for (int i = 0; i < 600; i++) begin
            a_wr_valid = ($urandom_range(0, 9) < 7);
            a_rd_ready = ($urandom_range(0, 9) < 6);
            a_flush    = ($urandom_range(0, 63) == 0);
            a_wr_data  = 16'($urandom);
            b_wr_valid = ($urandom_range(0, 9) < 5);
            b_rd_ready = ($urandom_range(0, 9) < 8);
            b_flush    = ($urandom_range(0, 63) == 0);
            b_wr_data  = $urandom;
            step();
        end
        a_wr_valid = 0; a_rd_ready = 0; a_flush = 0;
        b_wr_valid = 0; b_rd_ready = 0; b_flush = 0;
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_wconv.md
# sync_fifo_wconv

Synchronous single-clock FIFO with independent, integer-ratio write and read widths, in either direction (upsize or downsize). Storage is held in narrow units, and pointers advance by one unit or by RATIO units per access. Valid/ready handshakes, unit-granular fill level, programmable almost-full and almost-empty flags, synchronous flush and sticky error flags are provided. It replaces the fixed upsizing multi-write/single-read FIFO in the audio front-end datapath wherever packing or unpacking between stages is needed.

## Interface
- W_WIDTH, 16: write data width, bits.
- R_WIDTH, 32: read data width, bits. max(W,R) must be an integer multiple of min(W,R).
- DEPTH_U, 16: capacity in narrow units (U = min(W_WIDTH,R_WIDTH) bits). Power of two, multiple of RATIO.
- LSB_FIRST, 1: 1 = first narrow unit in time maps to bits [U-1:0] of the wide word; 0 = maps to the MS slice.
- AF_THRESH, DEPTH_U-RATIO: almost_full when level ≥ AF_THRESH.
- AE_THRESH, RATIO: almost_empty when level ≤ AE_THRESH.
- Derived: RATIO = max/min widths; LW = $clog2(DEPTH_U)+1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of contents and pointers.
- wr_valid  in  1  write request.
- wr_data  in  W_WIDTH  write word.
- wr_ready  out  1  space for one write word.
- rd_valid  out  1  at least one read word available.
- rd_data  out  R_WIDTH  current head read word, valid when rd_valid.
- rd_ready  in  1  consumer accepts head word.
- level  out  LW  occupancy in narrow units.
- almost_full  out  1  level ≥ AF_THRESH.
- almost_empty  out  1  level ≤ AE_THRESH.
- overflow  out  1  sticky: wr_valid while !wr_ready.
- underflow  out  1  sticky: rd_ready while !rd_valid.

## Operation
- WU = W_WIDTH/U and RU = R_WIDTH/U units per access; one of them is 1, the other is RATIO.
- wr_ready = (DEPTH_U − level) ≥ WU. rd_valid = level ≥ RU.
- Write fires on wr_valid && wr_ready: WU units are stored at wr_ptr..wr_ptr+WU−1 (mod DEPTH_U) and wr_ptr advances by WU.
- Read fires on rd_valid && rd_ready: rd_ptr advances by RU.
- Pointers are LW bits wide and wrap naturally. level = wr_ptr − rd_ptr, modulo 2^LW.
- Unit ordering within a wide word follows LSB_FIRST, identically for packing (upsize) and unpacking (downsize).
- Simultaneous write and read in one cycle are both legal. level changes by +WU−RU.
- A full FIFO accepts no write even when a read fires in the same cycle (wr_ready depends on registered level only). An empty FIFO never presents data in the same cycle a write fires.
- flush has priority over all else: pointers go to 0; overflow and underflow are cleared; any write or read in that cycle is dropped and does not set error flags.
- overflow and underflow stay set until flush or reset. Neither blocked access alters state.
- Memory contents are not reset. rd_data is don't-care while !rd_valid; the bench must not check it then.

## Timing
- Reset values: wr_ready=1, rd_valid=0, level=0, almost_empty=1, almost_full=(AF_THRESH==0), overflow=0, underflow=0, rd_data=X.
- rd_data is a combinational read of the head units (first-word-fall-through).
- Write-to-read latency is 1 cycle: the write that makes level ≥ RU fires at edge k, and rd_valid is high after edge k.
- All flags are derived combinationally from the registered pointers; no extra flag latency.
- Asserting rst_n low mid-transfer clears everything immediately. Partially packed units are discarded.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Shared package sync_fifo_pkg:
  - ratio and units-per-side functions.
  - Elaboration-time checks: width divisibility, power-of-two DEPTH_U, DEPTH_U % RATIO == 0, thresholds ≤ DEPTH_U.
  - Reused by the existing FIFO family.
- Sub-module sync_fifo_wconv_ram: DEPTH_U×U register array with a WU-unit write port and an RU-unit combinational read port, both addressed by unit pointer with wrap. The top level holds only pointers, flags and unit reordering.

## Test plan
- W16/R32, LSB_FIRST=1: write 0x1111, 0x2222 → rd_valid rises after the 2nd write; rd_data=0x2222_1111. level goes 0→1→2 units, then 0 after the read.
- W32/R16, LSB_FIRST=0: write 0xAAAA_BBBB → reads return 0xAAAA then 0xBBBB; level 2→1→0.
- W16/R32, DEPTH_U=16: 16 writes with no reads → wr_ready=0 at level=16; a 17th wr_valid sets overflow and level stays 16; flush → level=0, overflow=0.
- Read on empty: rd_ready=1 at level=0 → underflow=1, pointers unchanged; a subsequent valid write/read pair behaves normally.
- Steady state W16/R32 at level=8, write every cycle, read every 2nd cycle → level constant over the window, no data loss; scoreboard compares 64 words.
- Assert rst_n low at level=5 (odd unit count) → all outputs at reset values immediately; subsequent traffic is ordered correctly with no stale unit.
